// File: rtl/tile_fetch_buffer.sv
// Ping-pong input tile buffer: one AXI read burst per row fills one bank while the array reads the other.
// Read latency is one cycle; fetching stalls on arready/rvalid and start waits until the fill bank is released.
module tile_fetch_buffer #(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int KSIZE = 3,
  parameter int POY   = 3,
  parameter int BURST = 32,
  parameter int ROWS  = (POY-1)*2+KSIZE,
  parameter int RW    = $clog2(ROWS),
  parameter int CW    = $clog2(BURST)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_pitch,
  input  logic          stride2,
  input  logic [1:0]    pad_rows,
  output logic          can_start,
  output logic [AW-1:0] araddr,
  output logic [7:0]    arlen,
  output logic          arvalid,
  input  logic          arready,
  input  logic [DW-1:0] rdata,
  input  logic          rvalid,
  input  logic          rlast,
  output logic          rready,
  output logic          blkend,
  output logic [1:0]    bank_ready,
  input  logic          rel,
  input  logic          rel_bank,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          err
);

  localparam int NW = RW + 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST-1);
  localparam logic [NW-1:0] NROWS_S1  = NW'((POY-1)+KSIZE);
  localparam logic [NW-1:0] NROWS_S2  = NW'((POY-1)*2+KSIZE);

  logic [1:0]              state_q, state_d;
  logic                    fill_q, fill_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           beat_q, beat_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [AW-1:0]           pitch_q, pitch_d;
  logic [1:0][NW-1:0]      nrows_q, nrows_d;
  logic [1:0][ROWS-1:0]    zero_row_q, zero_row_d;
  logic [1:0]              bank_ready_q, bank_ready_d;
  logic                    err_q, err_d;
  logic                    blkend_q, blkend_d;
  logic                    rd_valid_q;
  logic [DW-1:0]           rd_data_q;
  logic [DW-1:0]           mem [2][ROWS][BURST];

  logic                    start_ok;
  logic                    last_beat;
  logic                    last_row;
  logic                    complete;
  logic [NW-1:0]           nrows_in;

  assign can_start = (state_q == S_IDLE) && !bank_ready_q[fill_q];
  assign start_ok  = start && can_start;
  assign last_beat = (beat_q == LAST_BEAT);
  assign last_row  = (NW'(row_q) == nrows_q[fill_q] - 1'b1);
  assign nrows_in  = stride2 ? NROWS_S2 : NROWS_S1;

  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    row_d        = row_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    pitch_d      = pitch_q;
    nrows_d      = nrows_q;
    zero_row_d   = zero_row_q;
    bank_ready_d = bank_ready_q;
    err_d        = err_q;
    blkend_d     = 1'b0;
    complete     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          addr_d          = base_addr;
          pitch_d         = row_pitch;
          nrows_d[fill_q] = nrows_in;
          row_d           = RW'(pad_rows);
          for (int r = 0; r < ROWS; r++) begin
            zero_row_d[fill_q][r] = (r < int'(pad_rows));
          end
          // All rows padded: nothing to fetch, the bank is complete at once.
          if (NW'(pad_rows) >= nrows_in) begin
            complete = 1'b1;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (arready) begin
          state_d = S_DATA;
          beat_d  = '0;
        end
      end
      S_DATA: begin
        if (rvalid) begin
          beat_d = beat_q + 1'b1;
          // Row length is fixed by beat count; rlast is only checked, never obeyed.
          if (rlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            if (last_row) begin
              complete = 1'b1;
            end else begin
              row_d   = row_q + 1'b1;
              addr_d  = addr_q + pitch_q;
              state_d = S_ADDR;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rel && !(rel_bank == fill_q && state_q != S_IDLE)) begin
      bank_ready_d[rel_bank] = 1'b0;
    end
    if (complete) begin
      bank_ready_d[fill_q] = 1'b1;
      blkend_d             = 1'b1;
      fill_d               = !fill_q;
      state_d              = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      fill_q       <= 1'b0;
      row_q        <= '0;
      beat_q       <= '0;
      addr_q       <= '0;
      pitch_q      <= '0;
      nrows_q      <= '0;
      zero_row_q   <= '0;
      bank_ready_q <= '0;
      err_q        <= 1'b0;
      blkend_q     <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      row_q        <= row_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      pitch_q      <= pitch_d;
      nrows_q      <= nrows_d;
      zero_row_q   <= zero_row_d;
      bank_ready_q <= bank_ready_d;
      err_q        <= err_d;
      blkend_q     <= blkend_d;
      rd_valid_q   <= rd_en;
      if (rd_en) begin
        // Row range is tested first so an out-of-range row never indexes storage.
        if (!bank_ready_q[rd_bank] || (NW'(rd_row) >= nrows_q[rd_bank]) ||
            zero_row_q[rd_bank][rd_row]) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= mem[rd_bank][rd_row][rd_col];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == S_DATA && rvalid) begin
      mem[fill_q][row_q][beat_q] <= rdata;
    end
  end

  assign araddr     = addr_q;
  assign arlen      = 8'(BURST-1);
  assign arvalid    = (state_q == S_ADDR);
  assign rready     = (state_q == S_DATA);
  assign blkend     = blkend_q;
  assign bank_ready = bank_ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign err        = err_q;

endmodule

// File: tb/tb_tile_fetch_buffer.sv
// Directed bench for tile_fetch_buffer: an AXI read responder feeds tagged row patterns and tests read them back.
module tb_tile_fetch_buffer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] base_addr;
  logic [31:0] row_pitch;
  logic        stride2;
  logic [1:0]  pad_rows;
  logic        can_start;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rlast;
  logic        rready;
  logic        blkend;
  logic [1:0]  bank_ready;
  logic        rel;
  logic        rel_bank;
  logic        rd_en;
  logic        rd_bank;
  logic [2:0]  rd_row;
  logic [4:0]  rd_col;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        err;

  int          tests_run;
  int          tests_failed;

  logic [31:0] ar_log [8];
  int          n_bursts;
  int          n_blkend;
  int          addr_moved;
  int          ar_stall;
  int          bg_bad;
  bit          timed_out;
  logic        blk_can_start;

  tile_fetch_buffer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .row_pitch(row_pitch),
    .stride2(stride2), .pad_rows(pad_rows), .can_start(can_start), .araddr(araddr),
    .arlen(arlen), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rvalid(rvalid),
    .rlast(rlast), .rready(rready), .blkend(blkend), .bank_ready(bank_ready), .rel(rel),
    .rel_bank(rel_bank), .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row), .rd_col(rd_col),
    .rd_data(rd_data), .rd_valid(rd_valid), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] pat(input logic [7:0] tag, input int row, input int beat);
    return {tag, 8'h5A, 8'(row), 8'(beat)};
  endfunction

  task automatic do_start(input logic [31:0] b, input logic [31:0] p, input logic s2, input logic [1:0] pad);
    start = 1'b1; base_addr = b; row_pitch = p; stride2 = s2; pad_rows = pad;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_read(input logic b, input int r, input int c);
    rd_en = 1'b1; rd_bank = b; rd_row = 3'(r); rd_col = 5'(c);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_rel(input logic b);
    rel = 1'b1; rel_bank = b;
    @(negedge clk);
    rel = 1'b0;
  endtask

  // AXI responder, one negedge per cycle; optionally streams reads of bank 0 (tag 0x11) alongside.
  task automatic drive_fill(input logic [7:0] tag, input int row0, input int ar_delay, input bit r_alt,
                            input int bad_beat, input bit bg_en, input int stop_row, input int stop_beat);
    int row, beat, wcnt, bg_i, bg_row, bg_col;
    bit bg_pend, rtog, done;
    row = row0; beat = 0; wcnt = 0; bg_i = 0; bg_row = 0; bg_col = 0;
    bg_pend = 0; rtog = 0; done = 0;
    n_bursts = 0; n_blkend = 0; addr_moved = 0; ar_stall = 0; bg_bad = 0; timed_out = 0; blk_can_start = 1'bx;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bg_pend && (rd_valid !== 1'b1 || rd_data !== pat(8'h11, bg_row, bg_col))) bg_bad++;
      bg_pend = 0; rd_en = 1'b0;
      if (blkend === 1'b1) begin
        n_blkend++; blk_can_start = can_start; done = 1;
        break;
      end
      if (bg_en) begin
        bg_row = bg_i % 5; bg_col = (bg_i * 7) % 32; bg_i++;
        rd_en = 1'b1; rd_bank = 1'b0; rd_row = 3'(bg_row); rd_col = 5'(bg_col); bg_pend = 1;
      end
      arready = 1'b0;
      if (arvalid === 1'b1 && n_bursts < 8) begin
        if (wcnt == 0) ar_log[n_bursts] = araddr;
        else if (araddr !== ar_log[n_bursts]) addr_moved++;
        if (wcnt >= ar_delay) begin arready = 1'b1; wcnt = 0; n_bursts++; end
        else begin wcnt++; ar_stall++; end
      end
      rvalid = 1'b0; rlast = 1'b0;
      if (rready === 1'b1) begin
        rtog = !rtog;
        if (!r_alt || rtog) begin
          rvalid = 1'b1; rdata = pat(tag, row, beat);
          rlast = (row == row0 && bad_beat >= 0) ? (beat == bad_beat) : (beat == 31);
          if (row == stop_row && beat == stop_beat) begin rst = 1'b1; done = 1; end
          beat++;
          if (beat == 32) begin beat = 0; row++; end
        end
      end
      @(negedge clk);
      if (done) break;
    end
    if (!done) timed_out = 1;
    arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rd_en = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_arvalid: got %b want 0", arvalid); end
    tests_run++; if (rready !== 1'b0) begin tests_failed++; $display("FAIL rst_rready: got %b want 0", rready); end
    tests_run++; if (araddr !== 32'h0) begin tests_failed++; $display("FAIL rst_araddr: got %h want 0", araddr); end
    tests_run++; if (arlen !== 8'd31) begin tests_failed++; $display("FAIL rst_arlen: got %0d want 31", arlen); end
    tests_run++; if (blkend !== 1'b0) begin tests_failed++; $display("FAIL rst_blkend: got %b want 0", blkend); end
    tests_run++; if (bank_ready !== 2'b00) begin tests_failed++; $display("FAIL rst_bank_ready: got %b want 00", bank_ready); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rst_err: got %b want 0", err); end
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL rst_rd_data: got %h want 0", rd_data); end
    tests_run++; if (can_start !== 1'b1) begin tests_failed++; $display("FAIL rst_can_start: got %b want 1", can_start); end
  endtask

  task automatic test_stride1();
    do_start(32'h000A, 32'h400, 1'b0, 2'd0);
    tests_run++; if (arvalid !== 1'b1) begin tests_failed++; $display("FAIL s1_arvalid_t1: got %b want 1", arvalid); end
    drive_fill(8'h11, 0, 0, 1'b0, -1, 1'b0, -1, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL s1_timeout: got no blkend want blkend"); end
    tests_run++; if (n_bursts !== 5) begin tests_failed++; $display("FAIL s1_bursts: got %0d want 5", n_bursts); end
    for (int i = 0; i < 5; i++) begin
      tests_run++;
      if (ar_log[i] !== 32'h000A + 32'(i) * 32'h400) begin
        tests_failed++; $display("FAIL s1_araddr[%0d]: got %h want %h", i, ar_log[i], 32'h000A + 32'(i) * 32'h400);
      end
    end
    tests_run++; if (bank_ready !== 2'b01) begin tests_failed++; $display("FAIL s1_bank_ready: got %b want 01", bank_ready); end
    tests_run++; if (blk_can_start !== 1'b1) begin tests_failed++; $display("FAIL s1_can_start_at_blkend: got %b want 1", blk_can_start); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL s1_err: got %b want 0", err); end
    @(negedge clk);
    tests_run++; if (blkend !== 1'b0) begin tests_failed++; $display("FAIL s1_blkend_pulse: got %b want 0", blkend); end
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) begin
        do_read(1'b0, r, k * 15 + (k == 2 ? 1 : 0));
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== pat(8'h11, r, k * 15 + (k == 2 ? 1 : 0))) begin
          tests_failed++; $display("FAIL s1_read r%0d k%0d: got %b/%h want 1/%h", r, k, rd_valid, rd_data, pat(8'h11, r, k * 15 + (k == 2 ? 1 : 0)));
        end
      end
    end
    do_read(1'b0, 5, 0);
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL s1_read_row5: got %h want 0", rd_data); end
    do_read(1'b1, 0, 0);
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL s1_read_empty_bank1: got %h want 0", rd_data); end
  endtask

  task automatic test_ping_pong();
    do_start(32'h2000, 32'h100, 1'b1, 2'd0);
    tests_run++; if (arvalid !== 1'b1) begin tests_failed++; $display("FAIL pp_arvalid_t1: got %b want 1", arvalid); end
    drive_fill(8'h22, 0, 0, 1'b0, -1, 1'b1, -1, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL pp_timeout: got no blkend want blkend"); end
    tests_run++; if (n_bursts !== 7) begin tests_failed++; $display("FAIL pp_bursts: got %0d want 7", n_bursts); end
    tests_run++; if (ar_log[6] !== 32'h2600) begin tests_failed++; $display("FAIL pp_last_araddr: got %h want 2600", ar_log[6]); end
    tests_run++; if (bg_bad !== 0) begin tests_failed++; $display("FAIL pp_bank0_reads: got %0d bad want 0", bg_bad); end
    tests_run++; if (bank_ready !== 2'b11) begin tests_failed++; $display("FAIL pp_bank_ready: got %b want 11", bank_ready); end
    tests_run++; if (blk_can_start !== 1'b0) begin tests_failed++; $display("FAIL pp_can_start: got %b want 0", blk_can_start); end
    do_start(32'h7000, 32'h100, 1'b0, 2'd0);
    @(negedge clk);
    tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL pp_start_ignored: got %b want 0", arvalid); end
    do_read(1'b1, 6, 31);
    tests_run++; if (rd_data !== pat(8'h22, 6, 31)) begin tests_failed++; $display("FAIL pp_read_b1r6: got %h want %h", rd_data, pat(8'h22, 6, 31)); end
    do_rel(1'b0);
    tests_run++; if (bank_ready !== 2'b10) begin tests_failed++; $display("FAIL pp_rel_bank_ready: got %b want 10", bank_ready); end
    tests_run++; if (can_start !== 1'b1) begin tests_failed++; $display("FAIL pp_rel_can_start: got %b want 1", can_start); end
    do_read(1'b0, 0, 0);
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL pp_read_released: got %h want 0", rd_data); end
  endtask

  task automatic test_padding();
    do_start(32'h3000, 32'h80, 1'b0, 2'd1);
    drive_fill(8'h33, 1, 0, 1'b0, -1, 1'b0, -1, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL pad_timeout: got no blkend want blkend"); end
    tests_run++; if (n_bursts !== 4) begin tests_failed++; $display("FAIL pad_bursts: got %0d want 4", n_bursts); end
    tests_run++; if (ar_log[0] !== 32'h3000) begin tests_failed++; $display("FAIL pad_first_araddr: got %h want 3000", ar_log[0]); end
    tests_run++; if (ar_log[3] !== 32'h3180) begin tests_failed++; $display("FAIL pad_last_araddr: got %h want 3180", ar_log[3]); end
    tests_run++; if (bank_ready !== 2'b11) begin tests_failed++; $display("FAIL pad_bank_ready: got %b want 11", bank_ready); end
    do_read(1'b0, 0, 3);
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL pad_row0: got %h want 0", rd_data); end
    do_read(1'b0, 1, 0);
    tests_run++; if (rd_data !== pat(8'h33, 1, 0)) begin tests_failed++; $display("FAIL pad_row1: got %h want %h", rd_data, pat(8'h33, 1, 0)); end
    do_read(1'b0, 4, 31);
    tests_run++; if (rd_data !== pat(8'h33, 4, 31)) begin tests_failed++; $display("FAIL pad_row4: got %h want %h", rd_data, pat(8'h33, 4, 31)); end
    do_rel(1'b1);
    do_rel(1'b0);
    tests_run++; if (bank_ready !== 2'b00) begin tests_failed++; $display("FAIL pad_rel_both: got %b want 00", bank_ready); end
  endtask

  task automatic test_backpressure();
    do_start(32'h4000, 32'h200, 1'b0, 2'd0);
    drive_fill(8'h44, 0, 3, 1'b1, -1, 1'b0, -1, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL bp_timeout: got no blkend want blkend"); end
    tests_run++; if (n_bursts !== 5) begin tests_failed++; $display("FAIL bp_bursts: got %0d want 5", n_bursts); end
    tests_run++; if (ar_stall !== 15) begin tests_failed++; $display("FAIL bp_ar_stall: got %0d want 15", ar_stall); end
    tests_run++; if (addr_moved !== 0) begin tests_failed++; $display("FAIL bp_araddr_stable: got %0d changes want 0", addr_moved); end
    tests_run++; if (ar_log[4] !== 32'h4800) begin tests_failed++; $display("FAIL bp_last_araddr: got %h want 4800", ar_log[4]); end
    tests_run++; if (bank_ready !== 2'b10) begin tests_failed++; $display("FAIL bp_bank_ready: got %b want 10", bank_ready); end
    for (int r = 0; r < 5; r++) begin
      do_read(1'b1, r, (r * 9 + 17) % 32);
      tests_run++;
      if (rd_data !== pat(8'h44, r, (r * 9 + 17) % 32)) begin
        tests_failed++; $display("FAIL bp_read r%0d: got %h want %h", r, rd_data, pat(8'h44, r, (r * 9 + 17) % 32));
      end
    end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL bp_err: got %b want 0", err); end
    do_rel(1'b1);
  endtask

  task automatic test_burst_err();
    do_start(32'h5000, 32'h40, 1'b0, 2'd0);
    drive_fill(8'h55, 0, 0, 1'b0, 10, 1'b0, -1, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL be_timeout: got no blkend want blkend"); end
    tests_run++; if (n_blkend !== 1) begin tests_failed++; $display("FAIL be_blkend: got %0d want 1", n_blkend); end
    tests_run++; if (n_bursts !== 5) begin tests_failed++; $display("FAIL be_bursts: got %0d want 5", n_bursts); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL be_err: got %b want 1", err); end
    do_read(1'b0, 0, 31);
    tests_run++; if (rd_data !== pat(8'h55, 0, 31)) begin tests_failed++; $display("FAIL be_row0_beat31: got %h want %h", rd_data, pat(8'h55, 0, 31)); end
    do_read(1'b0, 1, 0);
    tests_run++; if (rd_data !== pat(8'h55, 1, 0)) begin tests_failed++; $display("FAIL be_row1_beat0: got %h want %h", rd_data, pat(8'h55, 1, 0)); end
    repeat (4) @(negedge clk);
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL be_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_mid();
    do_start(32'h6000, 32'h100, 1'b0, 2'd0);
    drive_fill(8'h66, 0, 0, 1'b0, -1, 1'b0, 2, 5);
    tests_run++; if (timed_out) begin tests_failed++; $display("FAIL rm_reach_beat: got timeout want row 2 beat 5"); end
    tests_run++; if (arvalid !== 1'b0) begin tests_failed++; $display("FAIL rm_arvalid: got %b want 0", arvalid); end
    tests_run++; if (rready !== 1'b0) begin tests_failed++; $display("FAIL rm_rready: got %b want 0", rready); end
    tests_run++; if (bank_ready !== 2'b00) begin tests_failed++; $display("FAIL rm_bank_ready: got %b want 00", bank_ready); end
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL rm_rd_data: got %h want 0", rd_data); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL rm_err: got %b want 0", err); end
    tests_run++; if (can_start !== 1'b1) begin tests_failed++; $display("FAIL rm_can_start: got %b want 1", can_start); end
    do_read(1'b0, 1, 0);
    tests_run++; if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL rm_read_after: got %h want 0", rd_data); end
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    rst = 1'b1; start = 1'b0; base_addr = '0; row_pitch = '0; stride2 = 1'b0; pad_rows = '0;
    arready = 1'b0; rdata = '0; rvalid = 1'b0; rlast = 1'b0; rel = 1'b0; rel_bank = 1'b0;
    rd_en = 1'b0; rd_bank = 1'b0; rd_row = '0; rd_col = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_stride1();
    test_ping_pong();
    test_padding();
    test_backpressure();
    test_burst_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
